stopwatch_ctrl: RTL and testbench

Control front-end that sits directly upstream of the stopwatch counter chain (deci → sec0 → sec1 → min). It conditions three raw push-buttons, runs the start/pause/lap/clear state machine, and divides the system clock into a one-cycle decisecond `tick`. It also emits a synchronous clear pulse and a display-freeze flag. Downstream counters advance only on `tick` and zero on `clr_pulse`.

---
 rtl/stopwatch_ctrl.sv | 163 ++++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control front-end: button conditioning, run/lap/pause FSM
// and decisecond prescaler feeding the downstream counter chain.
module stopwatch_ctrl #(
   parameter int DIV       = 10_000_000,
   parameter int DB_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_ss,
   input  logic btn_lap,
   input  logic btn_clr,
   output logic tick,
   output logic clr_pulse,
   output logic running,
   output logic lap_hold
);

   localparam int DBW = $clog2(DB_CYCLES);
   localparam int PW  = $clog2(DIV);
   localparam logic [DBW-1:0] DB_MAX  = DBW'(DB_CYCLES - 1);
   localparam logic [PW-1:0]  PRE_MAX = PW'(DIV - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      LAP   = 2'd2,
      PAUSE = 2'd3
   } state_e;

   // bit 0 = start/stop, bit 1 = lap, bit 2 = clear
   logic [2:0] btn_raw;
   logic [2:0] sync1_q, sync2_q;
   logic [2:0] level_q, level_d;
   logic [2:0] dly_q, press_q;
   logic [DBW-1:0] db_cnt_q [3];
   logic [DBW-1:0] db_cnt_d [3];

   state_e state_q, state_d;
   logic [PW-1:0] pre_q, pre_d;
   logic tick_q, tick_d;
   logic clr_q, clr_d;
   logic run_q, run_d;
   logic lap_q, lap_d;
   logic ev_ss, ev_lap, ev_clr;
   logic active;

   assign btn_raw = {btn_clr, btn_lap, btn_ss};
   assign ev_ss   = press_q[0];
   assign ev_lap  = press_q[1];
   assign ev_clr  = press_q[2];
   assign active  = (state_q == RUN) || (state_q == LAP);

   // Debounce: count consecutive cycles the synced level disagrees
   always_comb begin
      for (int i = 0; i < 3; i++) begin
         level_d[i]  = level_q[i];
         db_cnt_d[i] = '0;
         if (sync2_q[i] != level_q[i]) begin
            if (db_cnt_q[i] == DB_MAX) begin
               level_d[i] = ~level_q[i];
            end else begin
               db_cnt_d[i] = db_cnt_q[i] + DBW'(1);
            end
         end
      end
   end

   // Synchronizers, accepted levels and registered rising-edge pulses
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
         level_q <= '0;
         dly_q   <= '0;
         press_q <= '0;
         for (int i = 0; i < 3; i++) begin
            db_cnt_q[i] <= '0;
         end
      end else begin
         sync1_q <= btn_raw;
         sync2_q <= sync1_q;
         level_q <= level_d;
         dly_q   <= level_q;
         press_q <= level_q & ~dly_q;
         for (int i = 0; i < 3; i++) begin
            db_cnt_q[i] <= db_cnt_d[i];
         end
      end
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state: highest-priority legal event wins, others dropped
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (!ev_clr && ev_ss) state_d = RUN;
         end
         RUN: begin
            if (ev_ss)       state_d = PAUSE;
            else if (ev_lap) state_d = LAP;
         end
         LAP: begin
            if (ev_ss)       state_d = PAUSE;
            else if (ev_lap) state_d = RUN;
         end
         PAUSE: begin
            if (ev_clr)     state_d = IDLE;
            else if (ev_ss) state_d = RUN;
         end
         default: state_d = IDLE;
      endcase
   end

   // FSM outputs: clear only from IDLE/PAUSE, tick from current state
   always_comb begin
      clr_d  = ev_clr && ((state_q == IDLE) || (state_q == PAUSE));
      tick_d = active && (pre_q == PRE_MAX);
      run_d  = (state_d == RUN) || (state_d == LAP);
      lap_d  = (state_d == LAP);
   end

   // Prescaler: counts while active, holds in PAUSE, zero otherwise
   always_comb begin
      pre_d = pre_q;
      if (clr_d || (state_q == IDLE)) begin
         pre_d = '0;
      end else if (active) begin
         pre_d = (pre_q == PRE_MAX) ? '0 : pre_q + PW'(1);
      end
   end

   // Registered outputs and prescaler
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_q  <= '0;
         tick_q <= 1'b0;
         clr_q  <= 1'b0;
         run_q  <= 1'b0;
         lap_q  <= 1'b0;
      end else begin
         pre_q  <= pre_d;
         tick_q <= tick_d;
         clr_q  <= clr_d;
         run_q  <= run_d;
         lap_q  <= lap_d;
      end
   end

   assign tick      = tick_q;
   assign clr_pulse = clr_q;
   assign running   = run_q;
   assign lap_hold  = lap_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl (DIV=4, DB_CYCLES=3): expected
// output events are queued by cycle, a monitor matches observed events.
module tb_stopwatch_ctrl;

   localparam int K_TICK = 0;
   localparam int K_CLR  = 1;
   localparam int K_RUNR = 2;
   localparam int K_RUNF = 3;
   localparam int K_LAPR = 4;
   localparam int K_LAPF = 5;
   localparam int LAT    = 7;

   typedef struct {
      int cyc;
      int kind;
   } ev_t;

   logic clk = 1'b0;
   logic rst_n;
   logic btn_ss, btn_lap, btn_clr;
   logic tick, clr_pulse, running, lap_hold;

   int cyc = 0;
   int checks = 0;
   int errors = 0;
   bit mon_en = 1'b0;
   logic prev_run = 1'b0;
   logic prev_lap = 1'b0;
   ev_t exp_q[$];

   stopwatch_ctrl #(.DIV(4), .DB_CYCLES(3)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .btn_ss    (btn_ss),
      .btn_lap   (btn_lap),
      .btn_clr   (btn_clr),
      .tick      (tick),
      .clr_pulse (clr_pulse),
      .running   (running),
      .lap_hold  (lap_hold)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic string kname(input int k);
      case (k)
         K_TICK:  return "tick";
         K_CLR:   return "clr_pulse";
         K_RUNR:  return "running_rise";
         K_RUNF:  return "running_fall";
         K_LAPR:  return "lap_hold_rise";
         K_LAPF:  return "lap_hold_fall";
         default: return "unknown";
      endcase
   endfunction

   function automatic void push(input int c, input int k);
      ev_t e;
      int i;
      e.cyc  = c;
      e.kind = k;
      i = 0;
      while (i < exp_q.size() &&
             (exp_q[i].cyc < c ||
              (exp_q[i].cyc == c && exp_q[i].kind <= k)))
         i++;
      exp_q.insert(i, e);
   endfunction

   task automatic see(input int k);
      ev_t e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL unexpected_%s: seen at cycle %0d, none expected",
                  kname(k), cyc);
      end else begin
         e = exp_q.pop_front();
         if (e.cyc != cyc || e.kind != k) begin
            errors++;
            $display("FAIL event_%s: got %s at cycle %0d, expected %s at cycle %0d",
                     kname(k), kname(k), cyc, kname(e.kind), e.cyc);
         end
      end
   endtask

   task automatic monitor();
      ev_t e;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
               e = exp_q.pop_front();
               checks++;
               errors++;
               $display("FAIL missing_%s: expected at cycle %0d, absent at cycle %0d",
                        kname(e.kind), e.cyc, cyc);
            end
            if (tick)                   see(K_TICK);
            if (clr_pulse)              see(K_CLR);
            if (running && !prev_run)   see(K_RUNR);
            if (!running && prev_run)   see(K_RUNF);
            if (lap_hold && !prev_lap)  see(K_LAPR);
            if (!lap_hold && prev_lap)  see(K_LAPF);
            prev_run = running;
            prev_lap = lap_hold;
         end
      end
   endtask

   task automatic chk0(input string name, input logic act);
      checks++;
      if (act !== 1'b0) begin
         errors++;
         $display("FAIL %s: got %b, expected 0", name, act);
      end
   endtask

   task automatic outs_zero(input string tag);
      chk0({tag, "_tick"}, tick);
      chk0({tag, "_clr_pulse"}, clr_pulse);
      chk0({tag, "_running"}, running);
      chk0({tag, "_lap_hold"}, lap_hold);
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic press(input logic ss, input logic lap,
                        input logic clr, input int len);
      btn_ss  = ss;
      btn_lap = lap;
      btn_clr = clr;
      repeat (len) @(negedge clk);
      btn_ss  = 1'b0;
      btn_lap = 1'b0;
      btn_clr = 1'b0;
   endtask

   initial begin
      int r, p, t2, r2, t3, t4, t4b, t5, t6, p2, t7, t8, r3;
      ev_t e;
      rst_n   = 1'b0;
      btn_ss  = 1'b0;
      btn_lap = 1'b0;
      btn_clr = 1'b0;

      fork
         monitor();
         begin
            #200000;
            errors++;
            $display("FAIL watchdog: run exceeded time limit at cycle %0d", cyc);
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $fatal(1, "watchdog expired");
         end
      join_none

      repeat (3) @(negedge clk);
      outs_zero("in_reset");
      rst_n  = 1'b1;
      mon_en = 1'b1;
      repeat (50) @(negedge clk);
      outs_zero("idle_50");

      // Start: running at +7, ticks every 4 cycles
      r = cyc + LAT;
      push(r, K_RUNR);
      for (int k = 1; k <= 10; k++) push(r + 4 * k, K_TICK);
      // Pause acts at an edge where the count is 1
      p = r + 42;
      push(p, K_RUNF);
      press(1'b1, 1'b0, 1'b0, 10);
      wait_until(p - LAT);
      press(1'b1, 1'b0, 1'b0, 10);

      // Glitch train while paused: no events expected
      wait_until(p + 12);
      repeat (5) begin
         btn_ss = 1'b1;
         repeat (2) @(negedge clk);
         btn_ss = 1'b0;
         repeat (2) @(negedge clk);
      end

      // Resume with held count 2, then lap sequence and held-ss pause
      t2  = p + 40;
      r2  = t2 + LAT;
      t3  = r2 + 10;
      t4  = t3 + 20;
      t4b = t4 + 20;
      t5  = t4b + 20;
      t6  = t5 + 20;
      p2  = t6 + LAT;
      push(r2, K_RUNR);
      for (int c = r2 + 2; c <= p2; c += 4) push(c, K_TICK);
      push(t3 + LAT, K_LAPR);
      push(t4 + LAT, K_LAPF);
      push(t5 + LAT, K_LAPR);
      push(p2, K_RUNF);
      push(p2, K_LAPF);
      wait_until(t2);
      press(1'b1, 1'b0, 1'b0, 6);
      wait_until(t3);
      press(1'b0, 1'b1, 1'b0, 10);
      wait_until(t4);
      press(1'b0, 1'b1, 1'b0, 10);
      wait_until(t4b);
      press(1'b0, 1'b0, 1'b1, 10);
      wait_until(t5);
      press(1'b0, 1'b1, 1'b0, 10);
      wait_until(t6);
      press(1'b1, 1'b0, 1'b0, 100);

      // Clear and start together in PAUSE: clear wins, back to IDLE
      t7 = t6 + 115;
      push(t7 + LAT, K_CLR);
      wait_until(t7);
      press(1'b1, 1'b0, 1'b1, 10);

      // Fresh start: prescaler was zeroed, first tick DIV cycles later
      t8 = t7 + 20;
      r3 = t8 + LAT;
      push(r3, K_RUNR);
      push(r3 + 4, K_TICK);
      push(r3 + 8, K_TICK);
      wait_until(t8);
      press(1'b1, 1'b0, 1'b0, 10);
      wait_until(r3 + 10);
      @(posedge clk);

      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         errors++;
         $display("FAIL leftover_%s: expected at cycle %0d, never seen",
                  kname(e.kind), e.cyc);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
